// File: rtl/axi_stream_pkg.sv
// Shared AXI-Stream width-converter types, width helpers and ratio checks.
// Latency: none (package only).
// Backpressure: none (package only).
package axi_stream_pkg;

    localparam int DefNarrowWidth = 8;
    localparam int DefWideWidth   = 32;
    localparam int DefIdWidth     = 0;
    localparam int DefDestWidth   = 0;
    localparam int DefUserWidth   = 0;

    // A zero-width sideband field is carried as a single tied-off bit.
    function automatic int sig_w(input int width);
        return (width > 0) ? width : 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // Wide side must be a power-of-two multiple (>= 2) of a byte-aligned narrow side.
    function automatic bit dw_ratio_ok(input int narrow_w, input int wide_w);
        if (narrow_w <= 0 || (narrow_w % 8) != 0) begin
            return 1'b0;
        end
        if ((wide_w % narrow_w) != 0) begin
            return 1'b0;
        end
        return (wide_w / narrow_w >= 2) && is_pow2(wide_w / narrow_w);
    endfunction

    typedef logic [DefNarrowWidth-1:0]     narrow_data_t;
    typedef logic [DefNarrowWidth/8-1:0]   narrow_keep_t;
    typedef logic [DefWideWidth-1:0]       wide_data_t;
    typedef logic [DefWideWidth/8-1:0]     wide_keep_t;
    typedef logic [sig_w(DefIdWidth)-1:0]   id_t;
    typedef logic [sig_w(DefDestWidth)-1:0] dest_t;
    typedef logic [sig_w(DefUserWidth)-1:0] user_t;

    typedef struct packed {
        narrow_data_t data;
        narrow_keep_t keep;
        logic         last;
        id_t          id;
        dest_t        dest;
        user_t        user;
    } narrow_beat_t;

    typedef struct packed {
        wide_data_t data;
        wide_keep_t keep;
        logic       last;
        id_t        id;
        dest_t      dest;
        user_t      user;
    } wide_beat_t;

endpackage

// File: rtl/axi_stream_dw_upsizer_intf.sv
// Struct-port wrapper around axi_stream_dw_upsizer at the package default widths.
// Latency: 1 cycle (inherited). Backpressure: passed straight through to the core.
module axi_stream_dw_upsizer_intf
    import axi_stream_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_tvalid_i,
    output logic         in_tready_o,
    input  narrow_beat_t in_beat_i,
    output logic         out_tvalid_o,
    input  logic         out_tready_i,
    output wide_beat_t   out_beat_o
);

    axi_stream_dw_upsizer #(
        .DataWidthIn  (DefNarrowWidth),
        .DataWidthOut (DefWideWidth),
        .IdWidth      (DefIdWidth),
        .DestWidth    (DefDestWidth),
        .UserWidth    (DefUserWidth)
    ) u_upsizer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_tvalid_i  (in_tvalid_i),
        .in_tready_o  (in_tready_o),
        .in_tdata_i   (in_beat_i.data),
        .in_tkeep_i   (in_beat_i.keep),
        .in_tlast_i   (in_beat_i.last),
        .in_tid_i     (in_beat_i.id),
        .in_tdest_i   (in_beat_i.dest),
        .in_tuser_i   (in_beat_i.user),
        .out_tvalid_o (out_tvalid_o),
        .out_tready_i (out_tready_i),
        .out_tdata_o  (out_beat_o.data),
        .out_tkeep_o  (out_beat_o.keep),
        .out_tlast_o  (out_beat_o.last),
        .out_tid_o    (out_beat_o.id),
        .out_tdest_o  (out_beat_o.dest),
        .out_tuser_o  (out_beat_o.user)
    );

endmodule

// File: rtl/axi_stream_dw_upsizer.sv
// Packs R narrow AXI-Stream beats little-endian into one wide word; tlast closes a word early.
// Latency: 1 cycle from the completing input beat to out_tvalid_o.
// Backpressure: lanes 0..R-2 always accepted; completing beat waits for a free output register.
module axi_stream_dw_upsizer
    import axi_stream_pkg::*;
#(
    parameter int DataWidthIn  = 8,
    parameter int DataWidthOut = 32,
    parameter int IdWidth      = 0,
    parameter int DestWidth    = 0,
    parameter int UserWidth    = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_tvalid_i,
    output logic                          in_tready_o,
    input  logic [DataWidthIn-1:0]        in_tdata_i,
    input  logic [DataWidthIn/8-1:0]      in_tkeep_i,
    input  logic                          in_tlast_i,
    input  logic [sig_w(IdWidth)-1:0]     in_tid_i,
    input  logic [sig_w(DestWidth)-1:0]   in_tdest_i,
    input  logic [sig_w(UserWidth)-1:0]   in_tuser_i,
    output logic                          out_tvalid_o,
    input  logic                          out_tready_i,
    output logic [DataWidthOut-1:0]       out_tdata_o,
    output logic [DataWidthOut/8-1:0]     out_tkeep_o,
    output logic                          out_tlast_o,
    output logic [sig_w(IdWidth)-1:0]     out_tid_o,
    output logic [sig_w(DestWidth)-1:0]   out_tdest_o,
    output logic [sig_w(UserWidth)-1:0]   out_tuser_o
);

    localparam int Ratio    = DataWidthOut / DataWidthIn;
    localparam int KeepIn   = DataWidthIn / 8;
    localparam int KeepOut  = DataWidthOut / 8;
    localparam int CntW     = (Ratio >= 2) ? $clog2(Ratio) : 1;
    localparam int AccW     = (Ratio - 1) * DataWidthIn;
    localparam int AccKeepW = (Ratio - 1) * KeepIn;
    localparam int IdW      = sig_w(IdWidth);
    localparam int DestW    = sig_w(DestWidth);
    localparam logic [CntW-1:0] LastLane = CntW'(Ratio - 1);

    if (!dw_ratio_ok(DataWidthIn, DataWidthOut)) begin : g_bad_ratio
        $error("axi_stream_dw_upsizer: DataWidthOut/DataWidthIn must be a power of two >= 2 and DataWidthIn a multiple of 8");
    end

    logic [CntW-1:0]     cnt_q;
    logic [AccW-1:0]     acc_dat_q;
    logic [AccKeepW-1:0] acc_keep_q;
    logic [IdW-1:0]      acc_id_q;
    logic [DestW-1:0]    acc_dest_q;

    logic                completes;
    logic                out_free;
    logic                beat_hs;
    logic [DataWidthOut-1:0] word_dat;
    logic [KeepOut-1:0]      word_keep;
    logic [IdW-1:0]          word_id;
    logic [DestW-1:0]        word_dest;

    assign completes   = (cnt_q == LastLane) || in_tlast_i;
    assign out_free    = !out_tvalid_o || out_tready_i;
    assign in_tready_o = rst_i || !completes || out_free;
    assign beat_hs     = in_tvalid_i && in_tready_o;

    // Accumulator lanes at or above cnt_q are always zero, so inserting the
    // current beat yields the merged word with unused lanes already cleared.
    always_comb begin
        word_dat  = {{DataWidthIn{1'b0}}, acc_dat_q};
        word_keep = {{KeepIn{1'b0}}, acc_keep_q};
        for (int k = 0; k < Ratio; k++) begin
            if (cnt_q == CntW'(k)) begin
                word_dat[k*DataWidthIn +: DataWidthIn] = in_tdata_i;
                word_keep[k*KeepIn +: KeepIn]          = in_tkeep_i;
            end
        end
        word_id   = (cnt_q == '0) ? in_tid_i   : acc_id_q;
        word_dest = (cnt_q == '0) ? in_tdest_i : acc_dest_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            acc_dat_q  <= '0;
            acc_keep_q <= '0;
            acc_id_q   <= '0;
            acc_dest_q <= '0;
        end else if (beat_hs) begin
            if (completes) begin
                cnt_q      <= '0;
                acc_dat_q  <= '0;
                acc_keep_q <= '0;
            end else begin
                cnt_q      <= cnt_q + CntW'(1);
                acc_dat_q  <= word_dat[AccW-1:0];
                acc_keep_q <= word_keep[AccKeepW-1:0];
                if (cnt_q == '0) begin
                    acc_id_q   <= in_tid_i;
                    acc_dest_q <= in_tdest_i;
                end
            end
        end
    end

    // A completing beat only handshakes when the output register is free,
    // so loading here never overwrites an unaccepted word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_tvalid_o <= 1'b0;
            out_tdata_o  <= '0;
            out_tkeep_o  <= '0;
            out_tlast_o  <= 1'b0;
            out_tid_o    <= '0;
            out_tdest_o  <= '0;
            out_tuser_o  <= '0;
        end else if (beat_hs && completes) begin
            out_tvalid_o <= 1'b1;
            out_tdata_o  <= word_dat;
            out_tkeep_o  <= word_keep;
            out_tlast_o  <= in_tlast_i;
            out_tid_o    <= word_id;
            out_tdest_o  <= word_dest;
            out_tuser_o  <= in_tuser_i;
        end else if (out_tready_i) begin
            out_tvalid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_stream_dw_upsizer.sv
// Scoreboard bench for the 8->32 upsizer: directed words plus a randomized 32->8 loopback feed.
module tb_axi_stream_dw_upsizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_tvalid;
    logic        in_tready;
    logic [7:0]  in_tdata;
    logic [0:0]  in_tkeep;
    logic        in_tlast;
    logic [0:0]  in_tid;
    logic [0:0]  in_tdest;
    logic [0:0]  in_tuser;
    logic        out_tvalid;
    logic        out_tready;
    logic [31:0] out_tdata;
    logic [3:0]  out_tkeep;
    logic        out_tlast;
    logic [0:0]  out_tid;
    logic [0:0]  out_tdest;
    logic [0:0]  out_tuser;

    always #5 clk = ~clk;

    axi_stream_dw_upsizer #(
        .DataWidthIn  (8),
        .DataWidthOut (32),
        .IdWidth      (0),
        .DestWidth    (0),
        .UserWidth    (0)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_tvalid_i  (in_tvalid),
        .in_tready_o  (in_tready),
        .in_tdata_i   (in_tdata),
        .in_tkeep_i   (in_tkeep),
        .in_tlast_i   (in_tlast),
        .in_tid_i     (in_tid),
        .in_tdest_i   (in_tdest),
        .in_tuser_i   (in_tuser),
        .out_tvalid_o (out_tvalid),
        .out_tready_i (out_tready),
        .out_tdata_o  (out_tdata),
        .out_tkeep_o  (out_tkeep),
        .out_tlast_o  (out_tlast),
        .out_tid_o    (out_tid),
        .out_tdest_o  (out_tdest),
        .out_tuser_o  (out_tuser)
    );

    typedef struct {
        logic [31:0] dat;
        logic [3:0]  keep;
        logic        last;
        logic        id;
        logic        dest;
        logic        user;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   prod_done;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] dat, input logic [3:0] keep, input logic last,
                            input logic id, input logic dest, input logic user);
        exp_t e;
        e.dat = dat; e.keep = keep; e.last = last; e.id = id; e.dest = dest; e.user = user;
        sb.push_back(e);
    endtask

    // Monitor: pops on every output handshake and checks that a stalled word stays put.
    logic        held_vld = 1'b0;
    logic [31:0] held_dat;
    logic [3:0]  held_keep;
    logic        held_last;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (rst) begin
            held_vld = 1'b0;
        end else begin
            if (held_vld) begin
                check("hold_valid", out_tvalid, 1);
                check("hold_data", out_tdata, held_dat);
                check("hold_keep", out_tkeep, held_keep);
                check("hold_last", out_tlast, held_last);
            end
            if (out_tvalid && out_tready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got data 0x%0h, expected no output word", out_tdata);
                end else begin
                    mon_e = sb.pop_front();
                    check("word_data", out_tdata, mon_e.dat);
                    check("word_keep", out_tkeep, mon_e.keep);
                    check("word_last", out_tlast, mon_e.last);
                    check("word_id",   out_tid,   mon_e.id);
                    check("word_dest", out_tdest, mon_e.dest);
                    check("word_user", out_tuser, mon_e.user);
                end
            end
            held_vld  = out_tvalid && !out_tready;
            held_dat  = out_tdata;
            held_keep = out_tkeep;
            held_last = out_tlast;
        end
    end

    // Drives one beat (dest = data bit 7) and returns how many cycles it waited for ready.
    task automatic send_beat(input logic [7:0] d, input logic l, input logic id, input logic usr,
                             output int stalls);
        bit done;
        in_tvalid = 1'b1;
        in_tdata  = d;
        in_tkeep  = 1'b1;
        in_tlast  = l;
        in_tid    = id;
        in_tdest  = d[7];
        in_tuser  = usr;
        stalls    = 0;
        done      = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_tready) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 500) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL send_timeout: beat 0x%0h waited %0d cycles, required < 500", d, stalls);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_tvalid = 1'b0;
    endtask

    // Sends n bytes of dat: id on the first beat, user (and last if requested) on the final one.
    task automatic send_bytes(input logic [31:0] dat, input int n, input logic last, output int stalls);
        int st;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            send_beat(dat[8*i +: 8], last && (i == n - 1), i == 0, i == n - 1, st);
            stalls += st;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st, st_a, st_b, st4, c0;
        logic [31:0] rdat;
        logic        rlast;
        logic [3:0]  rid, rus;

        rst = 1'b1; in_tvalid = 1'b0; in_tdata = '0; in_tkeep = '0; in_tlast = 1'b0;
        in_tid = '0; in_tdest = '0; in_tuser = '0; out_tready = 1'b0; prod_done = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_tvalid", out_tvalid, 0);
        check("rst_out_tlast", out_tlast, 0);
        check("rst_out_tdata", out_tdata, 0);
        check("rst_out_tkeep", out_tkeep, 0);
        check("rst_in_tready", in_tready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        out_tready = 1'b1;

        // Full word, valid one cycle after the fourth beat
        push_exp(32'h123456ef, 4'hf, 1'b1, 1'b1, 1'b1, 1'b1);
        send_beat(8'hef, 1'b0, 1'b1, 1'b0, st);
        send_beat(8'h56, 1'b0, 1'b0, 1'b0, st);
        send_beat(8'h34, 1'b0, 1'b0, 1'b0, st);
        check("full_valid_early", out_tvalid, 0);
        send_beat(8'h12, 1'b1, 1'b0, 1'b1, st);
        check("full_latency", out_tvalid, 1);
        drain("full_drain");

        // Early last, next beat packs into lane 0, single-beat word
        push_exp(32'h000056ef, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1);
        send_bytes(32'h000056ef, 2, 1'b1, st);
        push_exp(32'h0000bbaa, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1);
        send_bytes(32'h0000bbaa, 2, 1'b1, st);
        push_exp(32'h0000005a, 4'h1, 1'b1, 1'b1, 1'b0, 1'b1);
        send_bytes(32'h0000005a, 1, 1'b1, st);
        drain("early_drain");

        // Back-to-back words at one beat per cycle
        push_exp(32'h123456ef, 4'hf, 1'b0, 1'b1, 1'b1, 1'b1);
        push_exp(32'h123456ef, 4'hf, 1'b1, 1'b1, 1'b1, 1'b1);
        c0 = cyc;
        send_bytes(32'h123456ef, 4, 1'b0, st_a);
        send_bytes(32'h123456ef, 4, 1'b1, st_b);
        check("b2b_stalls", st_a + st_b, 0);
        check("b2b_cycles", cyc - c0, 8);
        drain("b2b_drain");

        // Backpressure: first word stalls 6 cycles; three beats accepted, fourth waits
        out_tready = 1'b0;
        push_exp(32'h123456ef, 4'hf, 1'b0, 1'b1, 1'b1, 1'b1);
        send_bytes(32'h123456ef, 4, 1'b0, st);
        check("bp_first_loaded", out_tvalid, 1);
        push_exp(32'h44332211, 4'hf, 1'b1, 1'b1, 1'b0, 1'b1);
        fork
            begin
                send_bytes(32'h00332211, 3, 1'b0, st_a);
                send_beat(8'h44, 1'b1, 1'b0, 1'b1, st4);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_tready = 1'b1;
            end
        join
        check("bp_three_accepted", st_a, 0);
        check("bp_fourth_stalls", st4, 3);
        check("bp_reload_valid", out_tvalid, 1);
        drain("bp_drain");

        // Reset mid-word discards the partial word
        send_beat(8'hef, 1'b0, 1'b1, 1'b0, st);
        send_beat(8'h56, 1'b0, 1'b0, 1'b0, st);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_tready", in_tready, 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_output", out_tvalid, 0);
        push_exp(32'h123456ef, 4'hf, 1'b1, 1'b1, 1'b1, 1'b1);
        send_bytes(32'h123456ef, 4, 1'b1, st);
        drain("midrst_drain");

        // Loopback: 32->8 beat feed with random gaps and random downstream ready
        fork
            begin
                for (int w = 0; w < 200; w++) begin
                    rdat  = $urandom;
                    rlast = ($urandom_range(0, 3) == 0);
                    rid   = 4'($urandom_range(0, 15));
                    rus   = 4'($urandom_range(0, 15));
                    push_exp(rdat, 4'hf, rlast, rid[0], rdat[7], rus[3]);
                    for (int i = 0; i < 4; i++) begin
                        repeat ($urandom_range(0, 2)) @(posedge clk);
                        #1;
                        send_beat(rdat[8*i +: 8], rlast && (i == 3), rid[i], rus[i], st);
                    end
                end
                prod_done = 1'b1;
            end
            begin
                int guard = 0;
                while (!(prod_done && sb.size() == 0) && guard < 20000) begin
                    @(posedge clk);
                    #1;
                    out_tready = ($urandom_range(0, 1) == 1);
                    guard++;
                end
                check("loop_complete", guard < 20000, 1);
                out_tready = 1'b1;
            end
        join
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
